// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: prioritised single-entry PC redirect holder with flush epoch and post-flush squash window
module fetch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid_i,
  input  logic [63:0] exc_target_i,
  input  logic        mispred_valid_i,
  input  logic [63:0] mispred_target_i,
  input  logic        pred_valid_i,
  input  logic [63:0] pred_target_i,
  input  logic        fetch_ready_i,
  output logic        branch_taken_o,
  output logic [63:0] branch_target_o,
  output logic        flush_o,
  output logic [3:0]  flush_id_o
);
  typedef enum logic [1:0] {IDLE, HOLD, SQUASH} state_t;
  typedef enum logic [1:0] {K_PRED, K_MIS, K_EXC} kind_t;
  state_t      state, state_nx;
  kind_t       kind, req_kind;
  logic [63:0] target, req_target;
  logic [3:0]  sq_cnt, sq_cnt_nx, flush_id;
  logic        flush, accept, flush_acc, req_valid, load;
  always_comb begin
    accept     = state == HOLD && fetch_ready_i;
    flush_acc  = accept && kind != K_PRED;
    req_kind   = exc_valid_i ? K_EXC : mispred_valid_i ? K_MIS : K_PRED;
    req_target = exc_valid_i ? exc_target_i : mispred_valid_i ? mispred_target_i : pred_target_i;
    // predicted redirects are stale inside the squash window and on the flush edge itself
    req_valid  = exc_valid_i || mispred_valid_i || (pred_valid_i && state != SQUASH && !flush_acc);
    load       = req_valid && (state != HOLD || accept || req_kind > kind);
    state_nx   = load ? HOLD :
                 (state == HOLD && !accept) ? HOLD :
                 flush_acc ? SQUASH :
                 (state == SQUASH && sq_cnt > 4'd1) ? SQUASH : IDLE;
    sq_cnt_nx  = state_nx != SQUASH ? 4'd0 : flush_acc ? 4'(FLUSH_CYCLES) : sq_cnt - 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sq_cnt   <= '0;
      kind     <= K_PRED;
      target   <= '0;
      flush    <= 1'b0;
      flush_id <= '0;
    end else begin
      state    <= state_nx;
      sq_cnt   <= sq_cnt_nx;
      flush    <= flush_acc;
      flush_id <= flush_id + {3'b0, flush_acc};
      if (load) begin
        kind   <= req_kind;
        target <= req_target & ~64'h7;
      end
    end
  end
  assign branch_taken_o  = state == HOLD;
  assign branch_target_o = target;
  assign flush_o         = flush;
  assign flush_id_o      = flush_id;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed vector table, corner sequences and randomized model comparison
module tb_fetch_redirect_ctrl;
  localparam int F = 2;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        exc_v = 0, mis_v = 0, pred_v = 0, rdy = 0;
  logic [63:0] exc_t = 0, mis_t = 0, pred_t = 0;
  logic        taken, flush;
  logic [63:0] tgt;
  logic [3:0]  fid;
  int          checks = 0, errors = 0;
  bit          m_valid, m_flush;
  int          m_kind, m_sq, m_fid;
  logic [63:0] m_tgt;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid_i(exc_v), .exc_target_i(exc_t),
    .mispred_valid_i(mis_v), .mispred_target_i(mis_t),
    .pred_valid_i(pred_v), .pred_target_i(pred_t),
    .fetch_ready_i(rdy),
    .branch_taken_o(taken), .branch_target_o(tgt),
    .flush_o(flush), .flush_id_o(fid)
  );

  typedef struct {
    logic e, m, p, r;
    logic [63:0] et, mt, pt;
    logic tk, fl;
    logic [63:0] tg;
    logic [3:0] id;
  } vec_t;
  vec_t tbl[26];

  function automatic vec_t v(logic e, logic [63:0] et, logic m, logic [63:0] mt, logic p,
                             logic [63:0] pt, logic r, logic tk, logic [63:0] tg, logic fl, logic [3:0] id);
    vec_t x;
    x.e = e; x.et = et; x.m = m; x.mt = mt; x.p = p; x.pt = pt; x.r = r;
    x.tk = tk; x.tg = tg; x.fl = fl; x.id = id;
    return x;
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_flush = 0; m_kind = 0; m_sq = 0; m_fid = 0; m_tgt = '0;
  endfunction

  // rank: 2 exception, 1 mispredict, 0 predicted
  function automatic void model_step();
    bit acc, facc, rv;
    int rk;
    logic [63:0] rt;
    acc = m_valid && rdy;
    facc = acc && m_kind > 0;
    rv = 0; rk = 0; rt = '0;
    if (exc_v) begin rv = 1; rk = 2; rt = exc_t; end
    else if (mis_v) begin rv = 1; rk = 1; rt = mis_t; end
    else if (pred_v && m_sq == 0 && !facc) begin rv = 1; rk = 0; rt = pred_t; end
    if (rv && (!m_valid || acc || rk > m_kind)) begin m_valid = 1; m_kind = rk; m_tgt = rt; end
    else if (acc) m_valid = 0;
    m_flush = facc;
    if (facc) m_fid = (m_fid + 1) % 16;
    m_sq = m_valid ? 0 : facc ? F : (m_sq > 0 ? m_sq - 1 : 0);
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk_outs(string n, logic tk, logic [63:0] tg, logic fl, logic [3:0] id);
    chk({n, " taken"}, 64'(taken), 64'(tk));
    if (tk) chk({n, " target"}, tgt, tg);
    chk({n, " flush"}, 64'(flush), 64'(fl));
    chk({n, " flush_id"}, 64'(fid), 64'(id));
  endtask

  task automatic drive(logic e, logic [63:0] et, logic m, logic [63:0] mt, logic p, logic [63:0] pt, logic r);
    exc_v = e; exc_t = et; mis_v = m; mis_t = mt; pred_v = p; pred_t = pt; rdy = r;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    chk_outs("reset", 1'b0, 64'h0, 1'b0, 4'h0);
    chk("reset target", tgt, 64'h0);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = v(0, 0, 0, 0, 1, 64'h8000_1004, 1, 1, 64'h8000_1000, 0, 0);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = v(0, 0, 0, 0, 1, 64'h9000, 0, 1, 64'h9000, 0, 0);
    tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 1, 64'h9000, 0, 0);
    tbl[4]  = v(0, 0, 0, 0, 0, 0, 0, 1, 64'h9000, 0, 0);
    tbl[5]  = v(0, 0, 1, 64'hA000, 0, 0, 0, 1, 64'hA000, 0, 0);
    tbl[6]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tbl[7]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[8]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[9]  = v(1, 64'h100, 1, 64'h200, 1, 64'h300, 1, 1, 64'h100, 0, 1);
    tbl[10] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    tbl[11] = v(0, 0, 0, 0, 1, 64'h400, 1, 0, 0, 0, 2);
    tbl[12] = v(0, 0, 0, 0, 1, 64'h400, 1, 0, 0, 0, 2);
    tbl[13] = v(0, 0, 0, 0, 1, 64'h408, 1, 1, 64'h408, 0, 2);
    tbl[14] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    tbl[15] = v(1, 64'h500, 0, 0, 0, 0, 1, 1, 64'h500, 0, 2);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3);
    tbl[17] = v(0, 0, 0, 0, 1, 64'h600, 1, 0, 0, 0, 3);
    tbl[18] = v(1, 64'h700, 0, 0, 0, 0, 1, 1, 64'h700, 0, 3);
    tbl[19] = v(0, 0, 0, 0, 1, 64'h600, 1, 0, 0, 1, 4);
    tbl[20] = v(0, 0, 0, 0, 1, 64'h600, 1, 0, 0, 0, 4);
    tbl[21] = v(0, 0, 0, 0, 1, 64'h600, 1, 0, 0, 0, 4);
    tbl[22] = v(0, 0, 0, 0, 1, 64'h608, 1, 1, 64'h608, 0, 4);
    tbl[23] = v(0, 0, 0, 0, 0, 0, 0, 1, 64'h608, 0, 4);
    tbl[24] = v(0, 0, 0, 0, 1, 64'h700, 0, 1, 64'h608, 0, 4);
    tbl[25] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4);

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].e, tbl[i].et, tbl[i].m, tbl[i].mt, tbl[i].p, tbl[i].pt, tbl[i].r);
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].tk, tbl[i].tg, tbl[i].fl, tbl[i].id);
    end

    // flush epoch wraps after sixteen mispredict accepts
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 64'h1000 + 64'(i * 8), 0, 0, 1);
      step();
      chk_outs($sformatf("mis%0d load", i), 1'b1, 64'h1000 + 64'(i * 8), 1'b0, 4'(i));
      drive(0, 0, 0, 0, 0, 0, 1);
      step();
      chk_outs($sformatf("mis%0d acc", i), 1'b0, 64'h0, 1'b1, 4'((i + 1) % 16));
    end

    // asynchronous reset while a redirect is held
    drive(1, 64'hDEAD_BEEF, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk_outs("hold", 1'b1, 64'hDEAD_BEE8, 1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async rst", 1'b0, 64'h0, 1'b0, 4'h0);
    chk("async rst target", tgt, 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) == 0, {$urandom, $urandom},
            $urandom_range(0, 5) == 0, {$urandom, $urandom},
            $urandom_range(0, 2) == 0, {$urandom, $urandom},
            $urandom_range(0, 9) < 6);
      step();
      chk_outs($sformatf("rnd%0d", c), m_valid, {m_tgt[63:3], 3'b0}, m_flush, 4'(m_fid));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Collects PC redirect requests from three sources and issues exactly one redirect at a time to the PC fetch stage over a branch_taken/branch_target pair. The sources are exception/trap, execute-stage mispredict, and decode-stage predicted-taken branch. It resolves priority and holds a redirect until the fetch stage accepts it. After any exception or mispredict it maintains a 4-bit flush epoch and a post-flush squash window in which stale predicted redirects are dropped. It sits between the backend/decode and the fetch PC generator.

## Interface
- FLUSH_CYCLES, 2: cycles after an accepted exception/mispredict redirect during which predicted redirects are dropped; legal range 1..15.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exc_valid_i  in  1  exception/trap redirect request, highest priority
- exc_target_i  in  64  exception handler address
- mispred_valid_i  in  1  execute mispredict redirect request
- mispred_target_i  in  64  corrected PC
- pred_valid_i  in  1  decode predicted-taken redirect, lowest priority
- pred_target_i  in  64  predicted target
- fetch_ready_i  in  1  fetch stage accepts a redirect this cycle
- branch_taken_o  out  1  redirect valid, drives the fetch PC generator
- branch_target_o  out  64  redirect target, bits [2:0] forced to 0
- flush_o  out  1  one-cycle pulse after an exception/mispredict redirect is accepted
- flush_id_o  out  4  current flush epoch

## Operation
- Priority: exc > mispred > pred. Only the highest-priority valid input in a cycle is considered.
- Pending register: valid, 64-bit target, kind (EXC/MIS/PRED). All outputs are driven from registers; no input-to-output combinational path.
- branch_taken_o = pending valid. branch_target_o = pending target with [2:0] cleared.
- Accept: branch_taken_o && fetch_ready_i. Pending clears at that clock edge unless it is reloaded in the same cycle.
- Load rule: an incoming request loads pending if pending is empty, or if pending is being accepted this cycle, or if the incoming kind is strictly higher priority than the pending kind.
  - An equal- or lower-priority request against an unaccepted pending entry is dropped. It is not queued.
- States:
  - IDLE: pending empty.
  - HOLD: pending valid.
  - SQUASH: pending empty, squash counter nonzero.
- Transitions:
  - IDLE -> HOLD on any load.
  - HOLD accept of PRED -> IDLE, or -> HOLD if reloaded in the same cycle.
  - HOLD accept of EXC/MIS -> SQUASH with counter = FLUSH_CYCLES, or -> HOLD if an EXC/MIS is reloaded in the same cycle.
  - SQUASH: counter decrements each cycle and returns to IDLE at 0. exc/mispred -> HOLD; pred_valid_i is ignored.
- A pred arriving in the same cycle as an EXC/MIS accept is dropped.
- flush_id: increments by 1 modulo 16 on every accepted EXC/MIS (15 -> 0). Not changed by PRED accepts.
- flush_o: asserted the cycle after an EXC/MIS accept; flush_id_o already shows the new value in that cycle.
- A squash window that follows an EXC/MIS accepted from HOLD while in SQUASH restarts at FLUSH_CYCLES.

## Timing
- Reset (async, any time, including mid-HOLD): pending cleared, state IDLE, squash counter 0, branch_taken_o=0, branch_target_o=0, flush_o=0, flush_id_o=0.
- Latency: request sampled at edge N -> branch_taken_o=1 from cycle N+1. With fetch_ready_i=1 in N+1, accepted at edge N+2 and branch_taken_o=0 in N+2 unless reloaded.
- Back-to-back: with fetch_ready_i held high, a new request every cycle yields branch_taken_o high every cycle.
- branch_target_o is stable while branch_taken_o=1 and not accepted, unless a strictly higher-priority request replaces it, in which case it updates on the next cycle.
- Squash window: covers the FLUSH_CYCLES cycles following the accept edge.

## Test plan
- Reset, then pred_valid_i=1 with target 0x8000_1004, fetch_ready_i=1 -> one cycle later branch_taken_o=1, branch_target_o=0x8000_1000; flush_o never asserts; flush_id_o stays 0.
- Pending PRED 0x9000 with fetch_ready_i=0 for 3 cycles, then mispred_valid_i with target 0xA000 -> target switches to 0xA000 next cycle. Set fetch_ready_i=1 -> accepted; flush_o pulses; flush_id_o=1.
- Simultaneous exc (0x100) + mispred (0x200) + pred (0x300), ready=1 -> only 0x100 issued; mispred and pred are dropped.
- FLUSH_CYCLES=2: after an EXC accept, pred_valid_i high for 3 cycles -> first two preds dropped, third issued. An exc during the window is issued and restarts the window.
- 16 consecutive mispredict accepts -> flush_id_o goes 1..15 then wraps to 0. rst_n low mid-HOLD -> all outputs 0 immediately, asynchronously.
